// File: rtl/vtc_pkg.sv
// Shared types and vector-word layout for the vector test controller.
// The DUT inputs sit above the expected-output bit in each stored word.
package vtc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam int EXP_BIT = 0;
    localparam int IN_LSB  = 1;

endpackage

// File: rtl/vtc_vec_mem.sv
// Vector storage: synchronous write, asynchronous read.
// Contents survive reset so a run can be repeated after an abort.
module vtc_vec_mem #(
    parameter int W     = 4,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vector_test_controller.sv
// Applies stored vectors to a combinational DUT, waits, and checks its output.
// Each vector costs APPLY + SETTLE_CYC settle cycles + CHECK.
module vector_test_controller
    import vtc_pkg::*;
#(
    parameter int IN_W       = 3,
    parameter int DEPTH      = 8,
    parameter int SETTLE_CYC = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_en,
    input  logic [$clog2(DEPTH)-1:0]   load_addr,
    input  logic [IN_W:0]              load_data,
    input  logic [$clog2(DEPTH):0]     num_vec,
    input  logic                       start,
    output logic [IN_W-1:0]            dut_in,
    input  logic                       dut_y,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     errors,
    output logic                       fail_valid,
    output logic [$clog2(DEPTH)-1:0]   fail_index,
    output logic                       fail_got
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] index;
    logic [CW-1:0] count;
    logic [CW-1:0] clamp;
    logic [SW-1:0] settle_cnt;
    logic          expected;
    logic [IN_W:0] word;
    logic          last;

    assign busy  = (state == APPLY) || (state == SETTLE) || (state == CHECK);
    assign done  = (state == DONE);
    assign clamp = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
    assign last  = ({1'b0, index} == (count - CW'(1)));

    vtc_vec_mem #(
        .W     (IN_W + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (load_en && !busy),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (index),
        .rdata (word)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (clamp == '0) ? DONE : APPLY;
                end
            end
            APPLY:  state_nxt = (SETTLE_CYC == 0) ? CHECK : SETTLE;
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = CHECK;
                end
            end
            CHECK:  state_nxt = last ? DONE : APPLY;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dut_in     <= '0;
            errors     <= '0;
            fail_valid <= 1'b0;
            fail_index <= '0;
            fail_got   <= 1'b0;
            index      <= '0;
            count      <= '0;
            settle_cnt <= '0;
            expected   <= 1'b0;
        end else begin
            fail_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        count  <= clamp;
                        errors <= '0;
                        index  <= '0;
                    end
                end
                APPLY: begin
                    dut_in     <= word[IN_W:IN_LSB];
                    expected   <= word[EXP_BIT];
                    settle_cnt <= SW'(SETTLE_CYC - 1);
                end
                SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                CHECK: begin
                    if (dut_y != expected) begin
                        // saturate rather than wrap
                        if (errors != CW'(DEPTH)) begin
                            errors <= errors + CW'(1);
                        end
                        fail_valid <= 1'b1;
                        fail_index <= index;
                        fail_got   <= dut_y;
                    end
                    if (!last) begin
                        index <= index + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_test_controller.sv
// Directed bench for vector_test_controller with a behavioural DUT model
// and a queue of expected failure reports.
module tb_vector_test_controller;

    localparam int IN_W  = 3;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            load_en = 1'b0;
    logic [AW-1:0]   load_addr = '0;
    logic [IN_W:0]   load_data = '0;
    logic [CW-1:0]   num_vec = '0;
    logic            start = 1'b0;
    logic [IN_W-1:0] dut_in;
    logic            dut_y;
    logic            busy;
    logic            done;
    logic [CW-1:0]   errors;
    logic            fail_valid;
    logic [AW-1:0]   fail_index;
    logic            fail_got;

    logic [3:0] shadow [DEPTH];
    logic [3:0] sb_q [$];
    int checks = 0;
    int n_err  = 0;

    always #5 clk = ~clk;

    function automatic logic model(input logic [2:0] v);
        logic a, b, c;
        a = v[2];
        b = v[1];
        c = v[0];
        return (~a & ~b & ~c) | (a & ~b & ~c) | (a & ~b & c);
    endfunction

    assign dut_y = model(dut_in);

    vector_test_controller #(
        .IN_W       (IN_W),
        .DEPTH      (DEPTH),
        .SETTLE_CYC (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .num_vec    (num_vec),
        .start      (start),
        .dut_in     (dut_in),
        .dut_y      (dut_y),
        .busy       (busy),
        .done       (done),
        .errors     (errors),
        .fail_valid (fail_valid),
        .fail_index (fail_index),
        .fail_got   (fail_got)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input logic [3:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a[AW-1:0];
        load_data = d;
        shadow[a] = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_errors"}, errors, 0);
        chk({tag, "_fvalid"}, fail_valid, 0);
        chk({tag, "_findex"}, fail_index, 0);
        chk({tag, "_fgot"}, fail_got, 0);
        chk({tag, "_dut_in"}, dut_in, 0);
    endtask

    // poke: cycle to pulse start/load_en while busy; abort: cycle to drop reset
    task automatic run(input int n, input int exp_done, input int exp_err,
                       input int poke, input int abort);
        int         m;
        int         lim;
        int         cyc;
        int         done_cyc;
        int         busy_cnt;
        logic       g;
        logic [3:0] e;
        sb_q.delete();
        m = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < m; i++) begin
            g = model(shadow[i][3:1]);
            if (shadow[i][0] != g) begin
                sb_q.push_back({i[2:0], g});
            end
        end
        @(negedge clk);
        num_vec = n[CW-1:0];
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lim      = (abort != 0) ? 40 : 100;
        cyc      = 1;
        done_cyc = 0;
        busy_cnt = 0;
        while (cyc <= lim && done_cyc == 0) begin
            if (busy) busy_cnt++;
            if (done) done_cyc = cyc;
            if (fail_valid) begin
                if (sb_q.size() == 0) begin
                    chk("fail_spurious", fail_valid, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("fail_index", fail_index, e[3:1]);
                    chk("fail_got", fail_got, e[0]);
                end
            end
            if (cyc == poke) begin
                start     = 1'b1;
                load_en   = 1'b1;
                load_addr = 3'd5;
                load_data = 4'b0000;
            end else if (cyc == poke + 1) begin
                start   = 1'b0;
                load_en = 1'b0;
            end
            if (abort != 0 && cyc == abort) reset = 1'b0;
            if (abort != 0 && cyc == abort + 1) begin
                check_zero("abort");
                reset = 1'b1;
                sb_q.delete();
            end
            @(posedge clk);
            #1 cyc++;
        end
        chk("done_cycle", done_cyc, exp_done);
        if (abort == 0) begin
            chk("busy_cycles", busy_cnt, exp_done - 1);
            chk("errors", errors, exp_err);
            chk("fails_pending", sb_q.size(), 0);
        end
    endtask

    initial begin
        logic [3:0] good [DEPTH];
        good = '{4'b0001, 4'b0010, 4'b0100, 4'b0110,
                 4'b1001, 4'b1011, 4'b1100, 4'b1110};

        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < DEPTH; i++) load(i, good[i]);
        run(8, 25, 0, 0, 0);
        chk("dut_in_hold", dut_in, shadow[7][3:1]);
        repeat (3) @(posedge clk);
        #1 chk("errors_hold", errors, 0);

        load(3, 4'b0111);
        run(8, 25, 1, 0, 0);
        load(3, good[3]);

        run(0, 1, 0, 0, 0);
        chk("dut_in_zero_run", dut_in, shadow[7][3:1]);

        run(12, 25, 0, 0, 0);

        run(8, 0, 0, 0, 14);
        run(8, 25, 0, 0, 0);

        run(8, 25, 0, 5, 0);
        run(8, 25, 0, 0, 0);

        for (int i = 0; i < DEPTH; i++) load(i, good[i] ^ 4'b0001);
        run(8, 25, 8, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, n_err);
        $finish;
    end

endmodule

// File: doc/vector_test_controller.md
VECTOR_TEST_CONTROLLER -- requirements
Module: vector_test_controller

Interface
REQ-001 SHALL have parameter IN_W, 3, number of DUT input bits per vector.
REQ-002 SHALL have parameter DEPTH, 8, number of vector memory entries.
REQ-003 SHALL have parameter SETTLE_CYC, 1, wait cycles between applying a vector and checking it (0 legal).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port load_en  input  1  write one vector word into memory.
REQ-007 SHALL have port load_addr  input  $clog2(DEPTH)  memory write address.
REQ-008 SHALL have port load_data  input  IN_W+1  vector word: [IN_W:1] DUT inputs (MSB = first DUT input), [0] expected output.
REQ-009 SHALL have port num_vec  input  $clog2(DEPTH)+1  vectors to run, sampled with start.
REQ-010 SHALL have port start  input  1  begin a run.
REQ-011 SHALL have port dut_in  output  IN_W  registered stimulus to the combinational DUT.
REQ-012 SHALL have port dut_y  input  1  DUT output.
REQ-013 SHALL have ports busy (output 1, run active), done (output 1, one-cycle end pulse), errors (output $clog2(DEPTH)+1, mismatch count of current/last run).
REQ-014 SHALL have ports fail_valid (output 1, one-cycle mismatch pulse), fail_index (output $clog2(DEPTH), failing vector index), fail_got (output 1, dut_y value at failure).

Function
REQ-015 FSM states SHALL be IDLE, APPLY, SETTLE, CHECK, DONE.
REQ-016 IDLE: start=1 SHALL latch min(num_vec, DEPTH), clear errors and index to 0, go to APPLY; or to DONE if the latched count is 0.
REQ-017 APPLY SHALL register dut_in <= mem[index][IN_W:1] and expected <= mem[index][0], then go to SETTLE (or CHECK if SETTLE_CYC=0).
REQ-018 SETTLE SHALL hold exactly SETTLE_CYC cycles via a down-counter, dut_in stable, then go to CHECK.
REQ-019 CHECK SHALL compare dut_y with expected; on mismatch errors increments by 1 and fail_valid, fail_index=index, fail_got=dut_y are registered and presented in the following cycle.
REQ-020 CHECK SHALL go to DONE when index = count-1, else increment index and go to APPLY.
REQ-021 Each vector SHALL take exactly 2+SETTLE_CYC cycles; done SHALL be high in cycle count*(2+SETTLE_CYC)+1 after the start-sampling edge.
REQ-022 DONE SHALL assert done for one cycle with busy=0 and return to IDLE; errors SHALL hold until the next accepted start.
REQ-023 busy SHALL be 1 in APPLY, SETTLE and CHECK only.
REQ-024 start while busy SHALL be ignored; load_en while busy SHALL be ignored; load_en in IDLE/DONE SHALL write mem[load_addr] on that edge.
REQ-025 dut_in SHALL hold its last applied value after a run and in IDLE.
REQ-026 errors cannot exceed DEPTH and SHALL NOT wrap.

Reset
REQ-027 reset=0 at a rising edge SHALL force IDLE, dut_in=0, busy=0, done=0, errors=0, fail_valid=0, fail_index=0, fail_got=0, index=0, settle counter=0.
REQ-028 Reset mid-run SHALL abort without a done pulse; vector memory contents SHALL NOT be reset.

Structure
REQ-029 Package vtc_pkg SHALL hold the state enum and vector-word field position constants (expected bit 0, inputs [IN_W:1]).
REQ-030 Vector storage SHALL be sub-module vtc_vec_mem (DEPTH x IN_W+1, sync write, async read).

Verification (DUT y = ~a~b~c | a~b~c | a~bc; vectors 0001,0010,0100,0110,1001,1011,1100,1110)
REQ-031 Load 8 correct vectors, num_vec=8, start -> busy 24 cycles, done at cycle 25, errors=0, no fail_valid.
REQ-032 Corrupt addr 3 to 0111, run 8 -> one fail_valid, fail_index=3, fail_got=0, errors=1.
REQ-033 num_vec=0, start -> done at cycle 1, busy never high, errors=0, dut_in unchanged.
REQ-034 num_vec=12 -> clamped to 8, done at cycle 25.
REQ-035 reset=0 during vector 4 -> next cycle IDLE, all outputs 0, no done; rerun gives errors=0 with memory intact.
REQ-036 start and load_en pulsed while busy -> no restart, memory unchanged, run completes normally.
